// File: rtl/lmmi_port_arbiter.sv
// Round-robin arbiter sharing one LMMI configuration port among NUM_REQ requesters.
// Optional watchdog: define LMMI_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYC cycles.
module lmmi_port_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int OFFSET_W    = 15,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         LMMICLK,
    input  logic                         LMMIRESETN,
    input  logic [NUM_REQ-1:0]           REQ_VALID,
    input  logic [NUM_REQ-1:0]           REQ_WRRD_N,
    input  logic [NUM_REQ*OFFSET_W-1:0]  REQ_OFFSET,
    input  logic [NUM_REQ*DATA_W-1:0]    REQ_WDATA,
    output logic [NUM_REQ-1:0]           REQ_DONE,
    output logic [DATA_W-1:0]            REQ_RDATA,
    output logic                         REQ_ERR,
    output logic                         BUSY,
    output logic                         LMMIREQUEST,
    output logic                         LMMIWRRD_N,
    output logic [OFFSET_W-1:0]          LMMIOFFSET,
    output logic [DATA_W-1:0]            LMMIWDATA,
    input  logic                         LMMIREADY,
    input  logic                         LMMIRDATAVALID,
    input  logic [DATA_W-1:0]            LMMIRDATA
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NREQ_L = (IDX_W+1)'(NUM_REQ);

    // Handshake: a requester holds REQ_VALID and its fields until its REQ_DONE pulse;
    // on the IP side LMMIREQUEST stays high with stable fields until LMMIREADY is sampled.
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_RD, ST_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_next;
    logic                r_req;
    logic                r_wrrd_n;
    logic [OFFSET_W-1:0] r_offset;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_found;
    logic [IDX_W-1:0]    w_gnt;
    logic [IDX_W:0]      w_scan;
    logic                w_gnt_wrrd;
    logic [OFFSET_W-1:0] w_gnt_off;
    logic [DATA_W-1:0]   w_gnt_wdata;
    logic                w_complete;
    logic                w_capture;
    logic                w_timeout;
    logic                w_to_fire;

    // First requesting index at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_scan >= NREQ_L) w_scan = w_scan - NREQ_L;
            if (!w_found && REQ_VALID[w_scan[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_wrrd  = 1'b0;
        w_gnt_off   = '0;
        w_gnt_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt == IDX_W'(i)) begin
                w_gnt_wrrd  = REQ_WRRD_N[i];
                w_gnt_off   = REQ_OFFSET[i*OFFSET_W +: OFFSET_W];
                w_gnt_wdata = REQ_WDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_complete = ((r_state == ST_ISSUE) && LMMIREADY && (r_wrrd_n || LMMIRDATAVALID))
                     || ((r_state == ST_WAIT_RD) && LMMIRDATAVALID);
    assign w_capture  = w_complete && !r_wrrd_n;
    assign w_to_fire  = w_timeout && !w_complete;
    assign w_ptr_next = (r_idx == IDX_W'(NUM_REQ-1)) ? '0 : r_idx + 1'b1;

`ifdef LMMI_TIMEOUT_EN
    logic [31:0] r_cnt;
    logic        r_err;

    assign w_timeout = ((r_state == ST_ISSUE) || (r_state == ST_WAIT_RD))
                    && (r_cnt == 32'(TIMEOUT_CYC-1));
    assign REQ_ERR   = (r_state == ST_RESP) && r_err;

    always_ff @(posedge LMMICLK or negedge LMMIRESETN) begin
        if (!LMMIRESETN) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_found) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if ((r_state == ST_ISSUE) || (r_state == ST_WAIT_RD)) begin
            r_cnt <= r_cnt + 32'd1;
            if (w_to_fire) r_err <= 1'b1;
        end
    end
`else
    // Watchdog disabled: a negative limit is not a legal configuration.
    assign w_timeout = (TIMEOUT_CYC < 0);
    assign REQ_ERR   = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_found) w_next = ST_ISSUE;
            ST_ISSUE: begin
                if (w_complete || w_to_fire) w_next = ST_RESP;
                else if (LMMIREADY)          w_next = ST_WAIT_RD;
            end
            ST_WAIT_RD: if (w_complete || w_to_fire) w_next = ST_RESP;
            ST_RESP:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge LMMICLK or negedge LMMIRESETN) begin
        if (!LMMIRESETN) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_ptr    <= '0;
            r_req    <= 1'b0;
            r_wrrd_n <= 1'b0;
            r_offset <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && w_found) begin
                r_idx    <= w_gnt;
                r_wrrd_n <= w_gnt_wrrd;
                r_offset <= w_gnt_off;
                r_wdata  <= w_gnt_wdata;
                r_req    <= 1'b1;
            end
            if ((r_state == ST_ISSUE) && (LMMIREADY || w_to_fire)) r_req <= 1'b0;
            if (w_capture)      r_rdata <= LMMIRDATA;
            else if (w_to_fire) r_rdata <= '1;
            if (r_state == ST_RESP) r_ptr <= w_ptr_next;
        end
    end

    always_comb begin
        REQ_DONE = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            REQ_DONE[i] = (r_state == ST_RESP) && (r_idx == IDX_W'(i));
        end
    end

    assign BUSY        = (r_state != ST_IDLE);
    assign REQ_RDATA   = r_rdata;
    assign LMMIREQUEST = r_req;
    assign LMMIWRRD_N  = r_wrrd_n;
    assign LMMIOFFSET  = r_offset;
    assign LMMIWDATA   = r_wdata;
endmodule

// File: tb/tb_lmmi_port_arbiter.sv
// Scoreboard bench for lmmi_port_arbiter: a behavioural IP responder, requester drivers,
// and a monitor that checks every issue and completion against an expected queue.
module tb_lmmi_port_arbiter;
    localparam int TO_CYC = 64;

    typedef struct packed {
        logic [1:0]  idx;
        logic        wr;
        logic [14:0] off;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } txn_t;

    logic        LMMICLK = 1'b0;
    logic        LMMIRESETN;
    logic [2:0]  REQ_VALID;
    logic [2:0]  REQ_WRRD_N;
    logic [44:0] REQ_OFFSET;
    logic [95:0] REQ_WDATA;
    logic [2:0]  REQ_DONE;
    logic [31:0] REQ_RDATA;
    logic        REQ_ERR;
    logic        BUSY;
    logic        LMMIREQUEST;
    logic        LMMIWRRD_N;
    logic [14:0] LMMIOFFSET;
    logic [31:0] LMMIWDATA;
    logic        LMMIREADY;
    logic        LMMIRDATAVALID;
    logic [31:0] LMMIRDATA;

    lmmi_port_arbiter #(
        .NUM_REQ(3), .OFFSET_W(15), .DATA_W(32), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .LMMICLK(LMMICLK), .LMMIRESETN(LMMIRESETN),
        .REQ_VALID(REQ_VALID), .REQ_WRRD_N(REQ_WRRD_N),
        .REQ_OFFSET(REQ_OFFSET), .REQ_WDATA(REQ_WDATA),
        .REQ_DONE(REQ_DONE), .REQ_RDATA(REQ_RDATA), .REQ_ERR(REQ_ERR), .BUSY(BUSY),
        .LMMIREQUEST(LMMIREQUEST), .LMMIWRRD_N(LMMIWRRD_N),
        .LMMIOFFSET(LMMIOFFSET), .LMMIWDATA(LMMIWDATA),
        .LMMIREADY(LMMIREADY), .LMMIRDATAVALID(LMMIRDATAVALID), .LMMIRDATA(LMMIRDATA)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    always #5 LMMICLK = ~LMMICLK;

    int cyc = 0;
    always @(posedge LMMICLK) cyc <= cyc + 1;

    int ntot = 0;
    int nbad = 0;

    txn_t        exp_q[$];
    txn_t        iss_q[$];
    int          m_ptr = 0;
    logic [31:0] m_rdata = '0;
    int          hold_left = 0;

    // IP responder configuration
    bit          ip_random = 0;
    int          ip_rdy_dly = 0;
    int          ip_rd_dly = 0;
    bit          ip_no_rdv = 0;
    bit          ip_ovr_en = 0;
    logic [31:0] ip_ovr_val = '0;
    int          ip_last_dly = 0;
    int          ip_done_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [14:0] off);
        return ip_ovr_en ? ip_ovr_val : {off, 2'b01, off};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge LMMICLK);
        if (LMMIRESETN && REQ_DONE != 3'b000) begin
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) REQ_VALID = 3'b000;
            end else begin
                REQ_VALID = REQ_VALID & ~REQ_DONE;
            end
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [14:0] off, input logic [31:0] wd);
        REQ_WRRD_N[i]         = wr;
        REQ_OFFSET[i*15 +: 15] = off;
        REQ_WDATA[i*32 +: 32]  = wd;
    endtask

    task automatic push_txn(input int i, input bit to_exp);
        txn_t e;
        e.idx = 2'(i);
        e.wr  = REQ_WRRD_N[i];
        e.off = REQ_OFFSET[i*15 +: 15];
        e.wd  = REQ_WDATA[i*32 +: 32];
        e.err = 1'b0;
        e.rd  = e.wr ? m_rdata : rd_val(e.off);
        iss_q.push_back(e);
        if (to_exp) begin
            m_rdata = e.rd;
            m_ptr   = (i + 1) % 3;
            exp_q.push_back(e);
        end
    endtask

    // All requesters in the mask wait together: they are served in index order starting at the pointer.
    task automatic push_round(input logic [2:0] m);
        int st;
        st = m_ptr;
        for (int k = 0; k < 3; k++) begin
            if (m[(st + k) % 3]) push_txn((st + k) % 3, 1'b1);
        end
    endtask

    // Every requester held high: each grant goes to whoever the pointer names.
    task automatic push_hold(input int n);
        for (int k = 0; k < n; k++) push_txn(m_ptr, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (n < budget && !(exp_q.size() == 0 && !BUSY && REQ_VALID == 3'b000));
        if (!(exp_q.size() == 0 && !BUSY && REQ_VALID == 3'b000)) begin
            chk("idle_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            iss_q.delete();
            REQ_VALID = 3'b000;
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_req"},   64'(LMMIREQUEST), 64'd0);
        chk({nm, "_wrrd"},  64'(LMMIWRRD_N),  64'd0);
        chk({nm, "_off"},   64'(LMMIOFFSET),  64'd0);
        chk({nm, "_wdata"}, 64'(LMMIWDATA),   64'd0);
        chk({nm, "_done"},  64'(REQ_DONE),    64'd0);
        chk({nm, "_rdata"}, 64'(REQ_RDATA),   64'd0);
        chk({nm, "_err"},   64'(REQ_ERR),     64'd0);
        chk({nm, "_busy"},  64'(BUSY),        64'd0);
    endtask

    // ---------------- behavioural LMMI target ----------------
    initial begin
        logic        rd;
        logic [14:0] off;
        int          d;
        int          r;
        LMMIREADY = 1'b0;
        LMMIRDATAVALID = 1'b0;
        LMMIRDATA = '0;
        forever begin
            @(posedge LMMICLK); #1;
            if (LMMIRESETN && LMMIREQUEST) begin
                rd  = !LMMIWRRD_N;
                off = LMMIOFFSET;
                if (ip_random) begin
                    d = $urandom_range(0, 3);
                    r = $urandom_range(0, 3);
                end else begin
                    d = ip_rdy_dly;
                    r = ip_rd_dly;
                end
                ip_last_dly = d;
                repeat (d) begin @(posedge LMMICLK); #1; end
                LMMIREADY = 1'b1;
                ip_done_cyc = cyc;
                if (rd && !ip_no_rdv && r == 0) begin
                    LMMIRDATAVALID = 1'b1;
                    LMMIRDATA = rd_val(off);
                end
                @(posedge LMMICLK); #1;
                LMMIREADY = 1'b0;
                LMMIRDATAVALID = 1'b0;
                LMMIRDATA = $urandom;
                if (rd && !ip_no_rdv && r > 0) begin
                    repeat (r - 1) begin @(posedge LMMICLK); #1; end
                    LMMIRDATAVALID = 1'b1;
                    LMMIRDATA = rd_val(off);
                    ip_done_cyc = cyc;
                    @(posedge LMMICLK); #1;
                    LMMIRDATAVALID = 1'b0;
                    LMMIRDATA = $urandom;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic       prev_req;
        logic [2:0] prev_done;
        int         hi_cnt;
        int         rise_cyc;
        txn_t       e;
        logic [2:0] vec;
        prev_req = 1'b0;
        prev_done = 3'b000;
        hi_cnt = 0;
        rise_cyc = 0;
        forever begin
            @(negedge LMMICLK);
            if (!LMMIRESETN) begin
                prev_req = 1'b0;
                prev_done = 3'b000;
                hi_cnt = 0;
            end else begin
                if (LMMIREQUEST && !prev_req) begin
                    rise_cyc = cyc;
                    hi_cnt = 1;
                    if (iss_q.size() == 0) begin
                        chk("unexpected_issue", 64'(LMMIOFFSET), 64'd0);
                    end else begin
                        e = iss_q.pop_front();
                        chk("issue_off", 64'(LMMIOFFSET), 64'(e.off));
                        chk("issue_wrrd", 64'(LMMIWRRD_N), 64'(e.wr));
                        if (e.wr) chk("issue_wdata", 64'(LMMIWDATA), 64'(e.wd));
                    end
                end else if (LMMIREQUEST) begin
                    hi_cnt++;
                end else if (prev_req) begin
                    chk("req_len", 64'(hi_cnt), 64'(ip_last_dly + 1));
                end
                if (REQ_DONE != 3'b000) begin
                    chk("done_gap", 64'(prev_done), 64'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'(REQ_DONE), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        vec = 3'b001 << e.idx;
                        chk("done_vec", 64'(REQ_DONE), 64'(vec));
                        chk("done_err", 64'(REQ_ERR), 64'(e.err));
                        chk("done_rdata", 64'(REQ_RDATA), 64'(e.rd));
                        if (e.err) chk("timeout_lat", 64'(cyc - rise_cyc), 64'(TO_CYC));
                        else       chk("done_lat", 64'(cyc), 64'(ip_done_cyc + 1));
                    end
                end
                prev_req = LMMIREQUEST;
                prev_done = REQ_DONE;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] mask;
        int         busy_low;
        LMMIRESETN = 1'b0;
        REQ_VALID  = 3'b000;
        REQ_WRRD_N = '0;
        REQ_OFFSET = '0;
        REQ_WDATA  = '0;
        repeat (3) @(negedge LMMICLK);
        check_zero("reset");

        // All three requesting out of reset, immediate READY: grants 0,1,2,0,1,2.
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 15'(i + 1), 32'h1111_1111 * (i + 1));
        REQ_VALID = 3'b111;
        ip_rdy_dly = 0;
        hold_left = 6;
        push_hold(6);
        @(negedge LMMICLK);
        LMMIRESETN = 1'b1;
        wait_idle(200);

        // Write from req0, READY two cycles into the request.
        set_req(0, 1'b1, 15'h0040, 32'h1234_5678);
        ip_rdy_dly = 1;
        push_round(3'b001);
        REQ_VALID = 3'b001;
        wait_idle(100);

        // Read from req1, data three cycles after READY.
        set_req(1, 1'b0, 15'h0100, 32'h0);
        ip_rdy_dly = 0;
        ip_rd_dly = 3;
        ip_ovr_en = 1;
        ip_ovr_val = 32'hCAFE_F00D;
        push_round(3'b010);
        REQ_VALID = 3'b010;
        wait_idle(100);

        // Read with data in the same cycle as READY.
        set_req(2, 1'b0, 15'h0200, 32'h0);
        ip_rd_dly = 0;
        ip_ovr_val = 32'h0000_A5A5;
        push_round(3'b100);
        REQ_VALID = 3'b100;
        wait_idle(100);
        ip_ovr_en = 0;

        // Random contention rounds with random target latencies.
        ip_random = 1;
        repeat (40) begin
            mask = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                if (mask[i]) set_req(i, 1'($urandom_range(0, 1)), 15'($urandom), $urandom);
            end
            push_round(mask);
            REQ_VALID = mask;
            wait_idle(500);
        end
        ip_random = 0;
        ip_rdy_dly = 0;
        ip_rd_dly = 0;

        // Read whose data never arrives.
        ip_no_rdv = 1;
`ifdef LMMI_TIMEOUT_EN
        set_req(0, 1'b0, 15'h0077, 32'h0);
        push_txn(0, 1'b1);
        exp_q[exp_q.size() - 1].err = 1'b1;
        exp_q[exp_q.size() - 1].rd  = 32'hFFFF_FFFF;
        m_rdata = 32'hFFFF_FFFF;
        REQ_VALID = 3'b001;
        wait_idle(TO_CYC + 50);
`endif
        set_req(0, 1'b0, 15'h0123, 32'h0);
        push_txn(0, 1'b0);
        REQ_VALID = 3'b001;
        busy_low = 0;
`ifdef LMMI_TIMEOUT_EN
        repeat (20) begin
`else
        repeat (200) begin
`endif
            tick();
            if (!BUSY) busy_low++;
        end
        chk("busy_hold", 64'(busy_low), 64'd0);
        chk("wait_rd_req_low", 64'(LMMIREQUEST), 64'd0);

        // Asynchronous reset in WAIT_RD with every requester high.
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 15'h0300 + 15'(i), 32'hA0 + 32'(i));
        REQ_VALID = 3'b111;
        #2;
        LMMIRESETN = 1'b0;
        #1;
        check_zero("async_reset");
        ip_no_rdv = 0;
        m_ptr = 0;
        m_rdata = '0;
        hold_left = 3;
        push_hold(3);
        tick();
        tick();
        LMMIRESETN = 1'b1;
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule
